lcd_char_display: RTL

Cycle-based receiver model of the HD44780-style character LCD driven by the CPU's memory-mapped LCD port. Samples `lcd_data`/`lcd_ctrl`/`lcd_enable` from the bus side and executes each transaction on the falling edge of enable. Keeps an 80-byte DDRAM, a cursor/address counter and a busy flag, and publishes written characters and a scan port for benches and video logic.

---
 rtl/lcd_pkg.sv | 66 ++++++
 rtl/lcd_ddram.sv | 42 ++++
 rtl/lcd_char_display.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character LCD receiver: bus encodings, command
// bit positions, DDRAM line layout, FSM states and the address-counter step.
package lcd_pkg;

    // lcd_ctrl bit positions and encodings
    localparam int   CTRL_RS  = 1;
    localparam int   CTRL_RW  = 0;
    localparam logic RS_CMD   = 1'b0;
    localparam logic RS_DATA  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Commands are decoded by their highest set bit
    localparam int CMD_BIT_DDRAM = 7;
    localparam int CMD_BIT_CGRAM = 6;
    localparam int CMD_BIT_FUNC  = 5;
    localparam int CMD_BIT_SHIFT = 4;
    localparam int CMD_BIT_DISP  = 3;
    localparam int CMD_BIT_ENTRY = 2;
    localparam int CMD_BIT_HOME  = 1;

    // DDRAM layout: two 40-character lines
    localparam logic [6:0] LINE1_BASE  = 7'h00;
    localparam logic [6:0] LINE1_END   = 7'h27;
    localparam logic [6:0] LINE2_BASE  = 7'h40;
    localparam logic [6:0] LINE2_END   = 7'h67;
    localparam logic [6:0] LINE_LEN    = 7'd40;
    localparam logic [6:0] DDRAM_DEPTH = 7'd80;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } lcd_state_t;

    // Next address counter value; DDRAM wraps between the two lines,
    // CGRAM simply wraps modulo 64.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                           input logic cgram);
        logic [6:0] nxt;
        if (cgram) begin
            nxt = inc ? {1'b0, ac[5:0] + 6'd1} : {1'b0, ac[5:0] - 6'd1};
        end else if (inc) begin
            if (ac == LINE1_END)      nxt = LINE2_BASE;
            else if (ac == LINE2_END) nxt = LINE1_BASE;
            else                      nxt = ac + 7'd1;
        end else begin
            if (ac == LINE2_BASE)      nxt = LINE1_END;
            else if (ac == LINE1_BASE) nxt = LINE2_END;
            else                       nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

    // Folds a requested DDRAM address into a legal one: the gap past the end
    // of a line jumps to the start of the other line.
    function automatic logic [6:0] ddram_legal(input logic [6:0] a);
        logic [6:0] r;
        if (a[5:0] < LINE_LEN[5:0]) r = a;
        else                        r = a[6] ? LINE1_BASE : LINE2_BASE;
        return r;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: one synchronous write port, one asynchronous host
// read port and one registered scan port. Line 2 (0x40..0x67) is stored
// after line 1, at physical index 40..79.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic [6:0] scan_addr,
    output logic [7:0] scan_char
);

    logic [7:0] mem [0:DDRAM_DEPTH-1];

    function automatic logic in_range(input logic [6:0] a);
        return a[5:0] < LINE_LEN[5:0];
    endfunction

    function automatic logic [6:0] phys(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + LINE_LEN) : {1'b0, a[5:0]};
    endfunction

    // Store one byte per cycle; addresses in the line gaps are dropped
    always_ff @(posedge clk) begin
        if (wr_en && in_range(wr_addr)) mem[phys(wr_addr)] <= wr_data;
    end

    assign rd_data = in_range(rd_addr) ? mem[phys(rd_addr)] : BLANK_CHAR;

    // Registered scan read, blank out of reset and for gap addresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  scan_char <= BLANK_CHAR;
        else if (in_range(scan_addr)) scan_char <= mem[phys(scan_addr)];
        else                          scan_char <= BLANK_CHAR;
    end

endmodule

// File: rtl/lcd_char_display.sv
// Cycle-based HD44780-style LCD receiver. The E strobe is synchronised,
// data/ctrl are captured while synced E is high, and each transaction runs
// on the synced falling edge of E. A blank-fill engine writes 0x20 into all
// 80 locations after reset (busy stays low) and after a clear command.
module lcd_char_display
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 4,
    parameter int unsigned CLEAR_CYCLES = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lcd_data_in,
    input  logic [1:0] lcd_ctrl,
    input  logic       lcd_enable,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic       overrun,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic [6:0] char_addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    input  logic [6:0] scan_addr,
    output logic [7:0] scan_char
);

    logic       e_s1, e_s2, e_d;
    logic [7:0] data_q;
    logic [1:0] ctrl_q;
    logic       e_fall;
    lcd_state_t state;
    logic [15:0] busy_cnt;
    logic [6:0] ac, ac_next;
    logic       inc_mode, cgram_mode;
    logic [6:0] fill_idx, fill_addr;
    logic       fill_active, host_wr;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data, rd_data;

    assign e_fall      = e_d & ~e_s2;
    assign ac_next     = ac_step(ac, inc_mode, cgram_mode);
    assign fill_active = fill_idx < DDRAM_DEPTH;
    assign fill_addr   = (fill_idx < LINE_LEN) ? fill_idx : fill_idx + (LINE2_BASE - LINE_LEN);
    // A host data write that will actually land in DDRAM this cycle
    assign host_wr     = e_fall && ctrl_q[CTRL_RS] == RS_DATA && ctrl_q[CTRL_RW] == RW_WRITE
                         && state == ST_IDLE && !cgram_mode;

    // Synchronise E and capture the bus while synced E is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_s1   <= 1'b0;
            e_s2   <= 1'b0;
            e_d    <= 1'b0;
            data_q <= 8'h00;
            ctrl_q <= 2'b00;
        end else begin
            e_s1 <= lcd_enable;
            e_s2 <= e_s1;
            e_d  <= e_s2;
            if (e_s2) begin
                data_q <= lcd_data_in;
                ctrl_q <= lcd_ctrl;
            end
        end
    end

    // Write-port arbitration: a host write wins, the fill waits one cycle
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ac;
        wr_data = data_q;
        if (host_wr) begin
            wr_en = 1'b1;
        end else if (fill_active) begin
            wr_en   = 1'b1;
            wr_addr = fill_addr;
            wr_data = BLANK_CHAR;
        end
    end

    lcd_ddram u_ddram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (ac),
        .rd_data   (rd_data),
        .scan_addr (scan_addr),
        .scan_char (scan_char)
    );

    // Drive read data while the host holds a read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_data_oe  <= 1'b0;
            lcd_data_out <= 8'h00;
        end else if (e_s2 && lcd_ctrl[CTRL_RW] == RW_READ) begin
            lcd_data_oe  <= 1'b1;
            lcd_data_out <= (lcd_ctrl[CTRL_RS] == RS_DATA) ? rd_data : {busy, ac};
        end else begin
            lcd_data_oe  <= 1'b0;
            lcd_data_out <= 8'h00;
        end
    end

    // Busy FSM, command/data execution and blank-fill sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            busy_cnt   <= 16'd0;
            overrun    <= 1'b0;
            char_valid <= 1'b0;
            char_data  <= 8'h00;
            char_addr  <= 7'h00;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            ac         <= LINE1_BASE;
            inc_mode   <= 1'b1;
            cgram_mode <= 1'b0;
            fill_idx   <= 7'd0;
        end else begin
            char_valid <= 1'b0;
            if (fill_active && !host_wr) fill_idx <= fill_idx + 7'd1;

            if (state != ST_IDLE) begin
                if (busy_cnt == 16'd0) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end else begin
                    busy_cnt <= busy_cnt - 16'd1;
                end
            end

            if (e_fall) begin
                if (ctrl_q[CTRL_RW] == RW_READ) begin
                    // Reads never block; only data reads move the counter
                    if (ctrl_q[CTRL_RS] == RS_DATA) ac <= ac_next;
                end else if (state != ST_IDLE) begin
                    overrun <= 1'b1;
                end else if (ctrl_q[CTRL_RS] == RS_DATA) begin
                    if (!cgram_mode) begin
                        char_valid <= 1'b1;
                        char_data  <= data_q;
                        char_addr  <= ac;
                    end
                    ac       <= ac_next;
                    state    <= ST_EXEC;
                    busy     <= 1'b1;
                    busy_cnt <= 16'(BUSY_CYCLES - 1);
                end else if (data_q != 8'h00) begin
                    state    <= ST_EXEC;
                    busy     <= 1'b1;
                    busy_cnt <= 16'(BUSY_CYCLES - 1);
                    if (data_q[CMD_BIT_DDRAM]) begin
                        cgram_mode <= 1'b0;
                        ac         <= ddram_legal(data_q[6:0]);
                    end else if (data_q[CMD_BIT_CGRAM]) begin
                        cgram_mode <= 1'b1;
                        ac         <= {1'b0, data_q[5:0]};
                    end else if (data_q[CMD_BIT_FUNC]) begin
                        // function set: nothing to model
                    end else if (data_q[CMD_BIT_SHIFT]) begin
                        if (!data_q[3]) ac <= ac_step(ac, data_q[2], cgram_mode);
                    end else if (data_q[CMD_BIT_DISP]) begin
                        disp_on   <= data_q[2];
                        cursor_on <= data_q[1];
                        blink_on  <= data_q[0];
                    end else if (data_q[CMD_BIT_ENTRY]) begin
                        inc_mode <= data_q[1];
                    end else if (data_q[CMD_BIT_HOME]) begin
                        // home and clear both re-address DDRAM
                        cgram_mode <= 1'b0;
                        ac         <= LINE1_BASE;
                    end else begin
                        state      <= ST_CLEAR;
                        busy_cnt   <= 16'(CLEAR_CYCLES - 1);
                        fill_idx   <= 7'd0;
                        cgram_mode <= 1'b0;
                        ac         <= LINE1_BASE;
                        inc_mode   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
